// File: rtl/sobel_pkg.sv
// Shared Sobel definitions: magnitude mode encodings, 3x3 kernels, FSM states and the saturating magnitude.
// Pure declarations, no logic of its own.
package sobel_pkg;

   localparam int MODE_SUM = 0;
   localparam int MODE_MAX = 1;

   // Wide enough for IMAGE_WIDTH/IMAGE_HEIGHT up to 4095 plus the flush overrun
   localparam int CNT_W = 13;

   // Row-major 3x3 taps, index = row*3 + col, row 0 is the oldest line
   localparam int signed SOBEL_KX [0:8] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
   localparam int signed SOBEL_KY [0:8] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   function automatic int sobel_mag(input int gx, input int gy, input int mode, input int px_size);
      int ax;
      int ay;
      int m;
      int lim;
      ax  = (gx < 0) ? -gx : gx;
      ay  = (gy < 0) ? -gy : gy;
      m   = (mode == MODE_MAX) ? ((ax > ay) ? ax : ay) : (ax + ay);
      lim = (1 << px_size) - 1;
      return (m > lim) ? lim : m;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel delay: dout is the pixel written IMAGE_WIDTH enables ago.
// Advances only when en is high; no flow control of its own.
module sobel_line_buffer #(
   parameter int PX_SIZE     = 8,
   parameter int IMAGE_WIDTH = 64
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               en,
   input  logic [PX_SIZE-1:0] din,
   output logic [PX_SIZE-1:0] dout
);

   localparam int AW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

   logic [PX_SIZE-1:0] mem [0:IMAGE_WIDTH-1];
   logic [AW-1:0]      ptr;

   assign dout = mem[ptr];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (ptr == AW'(IMAGE_WIDTH - 1)) ? '0 : ptr + AW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         mem[ptr] <= din;
      end
   end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel gradient magnitude; output 2 cycles after the window advance that completes a centre.
// Input stalls (input_ready low) for IMAGE_WIDTH+1 flush cycles per frame; output has no back-pressure.
module sobel_stream
   import sobel_pkg::*;
#(
   parameter int PX_SIZE      = 8,
   parameter int IMAGE_WIDTH  = 64,
   parameter int IMAGE_HEIGHT = 64,
   parameter int MODE         = 0
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [PX_SIZE-1:0] input_data,
   input  logic               input_data_valid,
   output logic               input_ready,
   output logic [PX_SIZE-1:0] output_data,
   output logic               output_data_valid,
   output logic               output_last
);

   localparam int GW = PX_SIZE + 4;

   state_t             state_q;
   state_t             state_nxt;
   logic               rdy_q;
   logic               accept;
   logic               adv;
   logic               flushing;
   logic [PX_SIZE-1:0] pix_in;
   logic [PX_SIZE-1:0] lb1_q;
   logic [PX_SIZE-1:0] lb2_q;

   logic [CNT_W-1:0]   col_cnt;
   logic [CNT_W-1:0]   row_cnt;
   logic [CNT_W-1:0]   cen_col;
   logic [CNT_W-1:0]   cen_row;
   logic               last_px;
   logic               flush_done;
   logic               emit;
   logic               border;
   logic               cen_last;

   logic [PX_SIZE-1:0] win [0:8];
   logic               w_vld;
   logic               w_zero;
   logic               w_last;
   logic signed [GW-1:0] gx_c;
   logic signed [GW-1:0] gy_c;
   logic signed [GW-1:0] gx_q;
   logic signed [GW-1:0] gy_q;
   logic               a_vld;
   logic               a_zero;
   logic               a_last;

   assign input_ready = rdy_q;
   assign accept      = input_data_valid && rdy_q;

   // col_cnt/row_cnt give the stream index of the pixel entering the window
   assign last_px    = (row_cnt == CNT_W'(IMAGE_HEIGHT - 1)) && (col_cnt == CNT_W'(IMAGE_WIDTH - 1));
   assign flush_done = (col_cnt == CNT_W'(IMAGE_WIDTH));
   assign emit       = (row_cnt >= CNT_W'(2)) || ((row_cnt == CNT_W'(1)) && (col_cnt != '0));
   assign border     = (cen_row == '0) || (cen_row == CNT_W'(IMAGE_HEIGHT - 1)) ||
                       (cen_col == '0) || (cen_col == CNT_W'(IMAGE_WIDTH - 1));
   assign cen_last   = (cen_row == CNT_W'(IMAGE_HEIGHT - 1)) && (cen_col == CNT_W'(IMAGE_WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_nxt = ST_RUN;
         ST_RUN:   if (accept && last_px) state_nxt = ST_FLUSH;
         ST_FLUSH: if (flush_done) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      flushing = (state_q == ST_FLUSH);
      adv      = accept || flushing;
      pix_in   = flushing ? '0 : input_data;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= (state_nxt != ST_FLUSH);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn || (flushing && flush_done)) begin
         col_cnt <= '0;
         row_cnt <= '0;
         cen_col <= '0;
         cen_row <= '0;
      end else if (adv) begin
         if (flushing) begin
            col_cnt <= col_cnt + CNT_W'(1);
         end else if (col_cnt == CNT_W'(IMAGE_WIDTH - 1)) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + CNT_W'(1);
         end else begin
            col_cnt <= col_cnt + CNT_W'(1);
         end
         if (emit) begin
            if (cen_col == CNT_W'(IMAGE_WIDTH - 1)) begin
               cen_col <= '0;
               cen_row <= cen_row + CNT_W'(1);
            end else begin
               cen_col <= cen_col + CNT_W'(1);
            end
         end
      end
   end

   sobel_line_buffer #(.PX_SIZE(PX_SIZE), .IMAGE_WIDTH(IMAGE_WIDTH)) u_lb1 (
      .clk    (clk),
      .resetn (resetn),
      .en     (adv),
      .din    (pix_in),
      .dout   (lb1_q)
   );

   sobel_line_buffer #(.PX_SIZE(PX_SIZE), .IMAGE_WIDTH(IMAGE_WIDTH)) u_lb2 (
      .clk    (clk),
      .resetn (resetn),
      .en     (adv),
      .din    (lb1_q),
      .dout   (lb2_q)
   );

   always_ff @(posedge clk) begin
      if (adv) begin
         win[0] <= win[1];
         win[1] <= win[2];
         win[2] <= lb2_q;
         win[3] <= win[4];
         win[4] <= win[5];
         win[5] <= lb1_q;
         win[6] <= win[7];
         win[7] <= win[8];
         win[8] <= pix_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         w_vld  <= 1'b0;
         w_zero <= 1'b0;
         w_last <= 1'b0;
      end else begin
         w_vld <= adv && emit;
         if (adv) begin
            w_zero <= border;
            w_last <= cen_last;
         end
      end
   end

   always_comb begin
      gx_c = '0;
      gy_c = '0;
      for (int i = 0; i < 9; i++) begin
         gx_c = gx_c + GW'(SOBEL_KX[i]) * $signed({4'b0000, win[i]});
         gy_c = gy_c + GW'(SOBEL_KY[i]) * $signed({4'b0000, win[i]});
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         a_vld  <= 1'b0;
         a_zero <= 1'b0;
         a_last <= 1'b0;
         gx_q   <= '0;
         gy_q   <= '0;
      end else begin
         a_vld  <= w_vld;
         a_zero <= w_zero;
         a_last <= w_last;
         gx_q   <= gx_c;
         gy_q   <= gy_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         output_data       <= '0;
         output_data_valid <= 1'b0;
         output_last       <= 1'b0;
      end else begin
         output_data_valid <= a_vld;
         output_last       <= a_vld && a_last;
         if (a_vld) begin
            output_data <= a_zero ? '0 : PX_SIZE'(sobel_mag(int'(gx_q), int'(gy_q), MODE, PX_SIZE));
         end
      end
   end

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: MODE 0 and MODE 1 instances share one input stream and are
// compared against a whole-image Sobel reference computed from the frame arrays.
module tb_sobel_stream;

   localparam int PX = 8;
   localparam int W  = 64;
   localparam int H  = 64;
   localparam int N  = W * H;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [PX-1:0] input_data = '0;
   logic          input_data_valid = 1'b0;
   logic          rdy0, rdy1, ov0, ov1, ol0, ol1;
   logic [PX-1:0] od0, od1;

   always #5 clk = ~clk;

   sobel_stream #(.PX_SIZE(PX), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .MODE(0)) dut0 (
      .clk(clk), .resetn(resetn), .input_data(input_data), .input_data_valid(input_data_valid),
      .input_ready(rdy0), .output_data(od0), .output_data_valid(ov0), .output_last(ol0));

   sobel_stream #(.PX_SIZE(PX), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .MODE(1)) dut1 (
      .clk(clk), .resetn(resetn), .input_data(input_data), .input_data_valid(input_data_valid),
      .input_ready(rdy1), .output_data(od1), .output_data_valid(ov1), .output_last(ol1));

   typedef struct {
      logic [PX-1:0] data;
      logic          last;
   } exp_t;

   int   img [2][H][W];
   exp_t q0[$];
   exp_t q1[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   out_cnt = 0;
   int   last_cnt = 0;
   int   rdy_low = 0;
   int   cyc = 0;
   int   lat_cyc = 0;
   int   first_out_cyc = -1;
   bit   chk_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: spec formulas applied directly to the whole image
   function automatic int model(input int f, input int r, input int c, input int mode);
      int gx, gy, ax, ay, m;
      if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
      gx = (img[f][r-1][c+1] + 2 * img[f][r][c+1] + img[f][r+1][c+1])
         - (img[f][r-1][c-1] + 2 * img[f][r][c-1] + img[f][r+1][c-1]);
      gy = (img[f][r+1][c-1] + 2 * img[f][r+1][c] + img[f][r+1][c+1])
         - (img[f][r-1][c-1] + 2 * img[f][r-1][c] + img[f][r-1][c+1]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      m  = (mode == 1) ? ((ax > ay) ? ax : ay) : ax + ay;
      return (m > 255) ? 255 : m;
   endfunction

   task automatic push_expected(input int f);
      exp_t e;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            e.last = (r == H - 1 && c == W - 1);
            e.data = PX'(model(f, r, c, 0));
            q0.push_back(e);
            e.data = PX'(model(f, r, c, 1));
            q1.push_back(e);
         end
      end
   endtask

   // gap: 0 = always valid, 1 = valid every other cycle, 2 = random
   task automatic send_frame(input int f, input int gap, input int npix);
      int  i = 0;
      int  guard = 0;
      bit  vld;
      while (i < npix && guard < 20000) begin
         @(negedge clk);
         guard++;
         vld = (gap == 0) ? 1'b1 : (gap == 1) ? ((guard % 2) == 0) : ($urandom_range(0, 2) != 0);
         input_data       = PX'(img[f][i / W][i % W]);
         input_data_valid = vld;
         if (vld && rdy0) begin
            if (i == W + 1) lat_cyc = cyc;
            i++;
         end
      end
      check("send_done", i, npix);
   endtask

   task automatic drain();
      @(negedge clk);
      input_data_valid = 1'b0;
      for (int k = 0; k < 400 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("q0_empty", q0.size(), 0);
      check("q1_empty", q1.size(), 0);
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (chk_en) begin
         exp_t e;
         check("valid_match", ov1, ov0);
         if (!rdy0) rdy_low++;
         if (ov0) begin
            out_cnt++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (ol0) last_cnt++;
            if (q0.size() == 0) check("extra_out0", 1, 0);
            else begin
               e = q0.pop_front();
               check("data_m0", od0, e.data);
               check("last_m0", ol0, e.last);
            end
         end else begin
            check("last_idle0", ol0, 0);
         end
         if (ov1) begin
            if (q1.size() == 0) check("extra_out1", 1, 0);
            else begin
               e = q1.pop_front();
               check("data_m1", od1, e.data);
               check("last_m1", ol1, e.last);
            end
         end
      end
   end

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      check("rst_rdy0", rdy0, 0);
      check("rst_rdy1", rdy1, 0);
      check("rst_vld", ov0, 0);
      check("rst_last", ol0, 0);
      check("rst_data", od0, 0);
      resetn = 1'b1;
      @(negedge clk);
      check("rdy_after_rst", rdy0, 1);
      chk_en = 1'b1;

      // Constant 100 frame, latency of the first centre
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[0][r][c] = 100;
      push_expected(0);
      out_cnt = 0; last_cnt = 0; first_out_cyc = -1;
      send_frame(0, 0, N);
      drain();
      check("const_count", out_cnt, N);
      check("const_last_once", last_cnt, 1);
      check("first_latency", first_out_cyc - lat_cyc, 3);

      // Column-index ramp
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[0][r][c] = c;
      push_expected(0);
      out_cnt = 0; last_cnt = 0;
      send_frame(0, 0, N);
      drain();
      check("ramp_count", out_cnt, N);
      check("ramp_last", last_cnt, 1);

      // Vertical step edge, without and with alternating valid gaps
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[0][r][c] = (c < 32) ? 0 : 255;
      for (int g = 0; g < 2; g++) begin
         push_expected(0);
         out_cnt = 0;
         send_frame(0, g, N);
         drain();
         check("step_count", out_cnt, N);
      end

      // Reset after 100 pixels, then a full random frame
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[0][r][c] = $urandom_range(0, 255);
      chk_en = 1'b0;
      send_frame(0, 0, 100);
      @(negedge clk);
      resetn = 1'b0;
      input_data_valid = 1'b0;
      @(negedge clk);
      chk_en = 1'b1;
      check("midrst_vld", ov0, 0);
      check("midrst_rdy", rdy0, 0);
      @(negedge clk);
      resetn = 1'b1;
      push_expected(0);
      out_cnt = 0; last_cnt = 0;
      send_frame(0, 0, N);
      drain();
      check("after_rst_count", out_cnt, N);
      check("after_rst_last", last_cnt, 1);

      // Two back-to-back random frames
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[f][r][c] = $urandom_range(0, 255);
      push_expected(0);
      push_expected(1);
      out_cnt = 0; last_cnt = 0; rdy_low = 0;
      send_frame(0, 0, N);
      send_frame(1, 0, N);
      check("b2b_ready_low", rdy_low, W + 1);
      drain();
      check("b2b_count", out_cnt, 2 * N);
      check("b2b_last", last_cnt, 2);

      // Random image with random valid gaps
      push_expected(1);
      out_cnt = 0;
      send_frame(1, 2, N);
      drain();
      check("gaps_count", out_cnt, N);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 SHALL have parameter PX_SIZE, default 8: pixel width in bits.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 64: pixels per line, legal range 3..4095.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 64: lines per frame, legal range 3..4095.
REQ-004 SHALL have parameter MODE, default 0: 0 = |Gx|+|Gy|, 1 = max(|Gx|,|Gy|).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-006 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port input_data, input, PX_SIZE bits: grey pixel, row-major raster order.
REQ-008 SHALL have port input_data_valid, input, 1 bit: input_data is valid this cycle.
REQ-009 SHALL have port input_ready, output, 1 bit: block accepts a pixel this cycle.
REQ-010 SHALL have port output_data, output, PX_SIZE bits: gradient magnitude pixel.
REQ-011 SHALL have port output_data_valid, output, 1 bit: output_data valid; no back-pressure, consumer always accepts.
REQ-012 SHALL have port output_last, output, 1 bit: high with the final output pixel of a frame.

Function
REQ-013 SHALL accept a pixel on a rising edge where input_data_valid=1 and input_ready=1; valid gaps of any length are legal and SHALL NOT alter results.
REQ-014 SHALL keep two line buffers of IMAGE_WIDTH pixels and a 3x3 window register set.
REQ-015 SHALL compute Gx=(p02+2p12+p22)-(p00+2p10+p20) and Gy=(p20+2p21+p22)-(p00+2p01+p02), signed, PX_SIZE+4 bits, no overflow.
REQ-016 SHALL saturate the MODE-selected magnitude to 2^PX_SIZE-1.
REQ-017 SHALL output 0 for every pixel in row 0, row IMAGE_HEIGHT-1, column 0 or column IMAGE_WIDTH-1.
REQ-018 SHALL emit exactly IMAGE_WIDTH*IMAGE_HEIGHT outputs per frame, row-major, one per accepted or flush pixel.
REQ-019 SHALL assert output_data_valid for centre pixel k exactly 2 cycles after the edge that advances the window with stream index k+IMAGE_WIDTH+1.
REQ-020 SHALL use FSM IDLE -> RUN on the first accepted pixel; RUN -> FLUSH on acceptance of pixel IMAGE_WIDTH*IMAGE_HEIGHT-1; FLUSH -> IDLE after IMAGE_WIDTH+1 cycles.
REQ-021 SHALL hold input_ready=1 in IDLE and RUN and input_ready=0 throughout FLUSH.
REQ-022 SHALL advance the window once per FLUSH cycle with zero-valued virtual pixels; these pixels only feed border outputs.
REQ-023 SHALL clear the column/line counters when entering IDLE, so a new frame may start on the first cycle after FLUSH ends.
REQ-024 SHALL assert output_last for one cycle, together with output pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1), and never at any other time.

Reset
REQ-025 SHALL, while resetn=0 at a clock edge, force state IDLE, counters 0, output_data=0, output_data_valid=0, output_last=0, and input_ready=0.
REQ-026 SHALL drive input_ready=1 on the first cycle after resetn returns to 1.
REQ-027 SHALL, on reset mid-frame, discard the partial frame with no further outputs; line buffer contents need not be cleared.

Structure
REQ-028 SHALL place MODE encodings, kernel coefficients and the saturating-magnitude function in shared package sobel_pkg.
REQ-029 SHALL implement the two line buffers as sub-module sobel_line_buffer, parametrised by PX_SIZE and IMAGE_WIDTH.

Verification
REQ-030 SHALL cover: 64x64 constant 100 frame -> 4096 outputs, all 0, output_last once.
REQ-031 SHALL cover: pixel = column index, MODE 0 and MODE 1 -> interior outputs 8, border outputs 0.
REQ-032 SHALL cover: columns 0-31 = 0 and 32-63 = 255 -> interior columns 31 and 32 = 255 (saturated from 1020), all other outputs 0.
REQ-033 SHALL cover: the REQ-032 image with input_data_valid low every other cycle -> output sequence identical to the gap-free run.
REQ-034 SHALL cover: reset after 100 pixels, then a full frame -> exactly 4096 outputs, matching the golden model.
REQ-035 SHALL cover: two back-to-back frames -> input_ready low for exactly 65 cycles between them, and 8192 outputs in total.
